alu_seq: RTL
============

// Module: alu_seq
// PURPOSE
//   Parametrised, handshaked successor of the 4-bit lab ALU. Executes one operation per transaction on
//   WIDTH-bit operands with registered result/flags. Logic/arith ops take one cycle; shifts and the
//   iterative shift-add multiply take multiple cycles. Sits between the datapath operand latch and the
//   writeback stage; valid/ready on both sides.
// PARAMETERS
//   WIDTH  8  operand/result width in bits; power of two, >= 4. Localparam SHW = $clog2(WIDTH).
// PORTS
//   clk            in   1      clock; all state updates on rising edge
//   rst            in   1      reset: synchronous, active-high
//   in_valid       in   1      op/a/b valid
//   in_ready       out  1      block can accept; equals (state==IDLE)
//   op             in   4      opcode, see BEHAVIOUR
//   a, b           in   WIDTH  operands; shifts use b[SHW-1:0] as amount
//   out_valid      out  1      result/flags valid; equals (state==DONE)
//   out_ready      in   1      consumer accepts result
//   result         out  WIDTH  registered result
//   flag_zero      out  1      result == 0
//   flag_carry     out  1      per-op carry, see BEHAVIOUR
//   flag_overflow  out  1      signed overflow (ADD/SUB only, else 0)
//   flag_cmp       out  1      compare outcome (SLT/EQ only, else 0)
//   busy           out  1      state==BUSY
// BEHAVIOUR
//   Reset (rst=1 at an edge): state=IDLE, result=0, all flags=0, counter=0; aborts any op in flight.
//   FSM: IDLE -accept-> DONE (single-cycle op, or shift amount 0) | BUSY (shift amount>0, MUL).
//        BUSY: one step per cycle; counter decrements; at last step -> DONE.
//        DONE: outputs held stable; out_valid&out_ready -> IDLE. No accept while in BUSY/DONE.
//   Accept = in_valid & in_ready; a, b, op latched at that edge; later changes to inputs are ignored.
//   Latency (accept edge -> out_valid high): 1 cycle single-cycle; 1+k for shift by k; 1+WIDTH for MUL.
//   Opcodes (sum = a + b_eff + cin, WIDTH+1 bits):
//     0 ADD: a+b; carry=sum[WIDTH]; ovf=(a[MSB]==b[MSB])&(res[MSB]!=a[MSB])
//     1 SUB: a+~b+1; carry=sum[WIDTH] (1 = no borrow, a>=b unsigned); ovf per two's complement
//     2 NOT: ~a  3 AND  4 OR  5 XOR: carry=0, ovf=0
//     6 SLT: res={0..,lt}, lt=sub_res[MSB]^sub_ovf (signed a<b); cmp=lt; carry=ovf=0
//     7 EQ:  res={0..,a==b}; cmp=(a==b); carry=ovf=0
//     8 SLL, 9 SRL, 10 SRA: shift by k=b[SHW-1:0], one bit per BUSY cycle; carry=last bit shifted
//       out (0 when k=0); SRA replicates a[MSB]
//     11 MUL: unsigned shift-add, WIDTH BUSY cycles, 2*WIDTH accumulator; res=low WIDTH bits;
//       carry=|high WIDTH bits (unsigned overflow); ovf=0
//     12-15 reserved: 1 cycle, res=0, zero=1, other flags 0
//   flag_zero always computed on final result, incl. MUL and shifts.
//   Wrap-around: ADD/SUB/MUL results truncate modulo 2^WIDTH; carry reports the loss.
//   Simultaneous: out_ready in same cycle out_valid rises -> handshake completes that edge; IDLE
//     next cycle, new accept possible then (max throughput 1 op / 2 cycles).
//   rst during BUSY/DONE: result discarded, no out_valid pulse; in_ready=1 cycle after reset.
// TESTING (WIDTH=8)
//   ADD a=0x7F b=0x01 -> res=0x80 ovf=1 carry=0 zero=0; out_valid 1 cycle after accept
//   SUB a=0x05 b=0x05 -> res=0x00 zero=1 carry=1 ovf=0; SUB 0x00-0x01 -> 0xFF carry=0
//   SLT a=0xFF b=0x01 -> res=0x01 cmp=1; EQ a=b=0x3C -> res=0x01 cmp=1
//   SRA a=0x80 b=3 -> res=0xF0 carry=0, out_valid 4 cycles after accept, busy=1 for 3 cycles;
//     SLL a=0x81 b=0 -> res=0x81 carry=0, 1-cycle latency
//   MUL a=0x10 b=0x20 -> res=0x00 zero=1 carry=1, latency 9; MUL 0x0F*0x0F -> 0xE1 carry=0
//   out_ready=0 for 5 cycles in DONE -> res/flags stable, in_ready=0; rst mid-MUL -> IDLE, outputs 0

Source files
------------

// File: rtl/alu_seq_if.sv
// ---------------------------------------------------------------------------
// alu_seq_if
//   Handshake bundle between the operand latch, the sequential ALU and the
//   writeback stage.
//   Request side : in_valid / in_ready, op[3:0], a, b
//   Response side: out_valid / out_ready, result, flag_zero, flag_carry,
//                  flag_overflow, flag_cmp
//   Status       : busy (multi-cycle operation in progress)
//   modport master : the side that issues operations and consumes results
//   modport slave  : the ALU itself
// ---------------------------------------------------------------------------
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             flag_zero;
    logic             flag_carry;
    logic             flag_overflow;
    logic             flag_cmp;
    logic             busy;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, flag_zero, flag_carry,
               flag_overflow, flag_cmp, busy
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, flag_zero, flag_carry,
               flag_overflow, flag_cmp, busy
    );
endinterface

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq
//   Handshaked sequential ALU. One operation per transaction on WIDTH-bit
//   operands. Logic/arithmetic/compare ops complete in one cycle; shifts
//   move one bit per cycle; MUL is an unsigned shift-add over WIDTH cycles.
//   Result and flags are registered and held while out_valid is high.
//
//   Ports
//     clk  : clock, all state changes on the rising edge
//     rst  : synchronous active-high reset, aborts any operation in flight
//     bus  : alu_seq_if.slave
//              in_valid/in_ready  accept op, a, b (in_ready == IDLE)
//              out_valid/out_ready deliver result + flags (out_valid == DONE)
//              busy               high while a multi-cycle op is stepping
//
//   Opcodes: 0 ADD, 1 SUB, 2 NOT, 3 AND, 4 OR, 5 XOR, 6 SLT, 7 EQ,
//            8 SLL, 9 SRL, 10 SRA, 11 MUL, 12-15 reserved (result 0).
// ---------------------------------------------------------------------------
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    alu_seq_if.slave   bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_NOT = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_SLT = 4'd6;
    localparam logic [3:0] OP_EQ  = 4'd7;
    localparam logic [3:0] OP_SLL = 4'd8;
    localparam logic [3:0] OP_SRL = 4'd9;
    localparam logic [3:0] OP_SRA = 4'd10;
    localparam logic [3:0] OP_MUL = 4'd11;

    localparam logic [SHW:0] CNT_ONE   = (SHW+1)'(1);
    localparam logic [SHW:0] CNT_WIDTH = (SHW+1)'(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_reg;
    logic [3:0]           op_reg;
    // Shift operand for shifts; multiplier (consumed LSB first) for MUL.
    logic [WIDTH-1:0]     work_reg;
    logic [2*WIDTH-1:0]   mcand_reg;
    logic [2*WIDTH-1:0]   acc_reg;
    logic [SHW:0]         cnt_reg;
    logic [WIDTH-1:0]     result_reg;
    logic                 zero_reg;
    logic                 carry_reg;
    logic                 ovf_reg;
    logic                 cmp_reg;

    // -----------------------------------------------------------------------
    // Single-cycle datapath, evaluated on the live inputs at the accept edge
    // -----------------------------------------------------------------------
    logic [WIDTH:0]       add_sum;
    logic [WIDTH:0]       sub_sum;
    logic                 add_ovf;
    logic                 sub_ovf;
    logic                 signed_lt;
    logic                 operands_eq;
    logic [WIDTH-1:0]     not_bits;
    logic [WIDTH-1:0]     and_bits;
    logic [WIDTH-1:0]     or_bits;
    logic [WIDTH-1:0]     xor_bits;
    logic [SHW-1:0]       shift_amt;
    logic                 is_shift;
    logic [WIDTH-1:0]     sc_res;
    logic                 sc_carry;
    logic                 sc_ovf;
    logic                 sc_cmp;

    assign add_sum     = {1'b0, bus.a} + {1'b0, bus.b};
    // SUB is a + ~b + 1 so the top bit is the "no borrow" carry.
    assign sub_sum     = {1'b0, bus.a} + {1'b0, ~bus.b} + (WIDTH+1)'(1);
    assign add_ovf     = (bus.a[MSB] == bus.b[MSB]) && (add_sum[MSB] != bus.a[MSB]);
    assign sub_ovf     = (bus.a[MSB] != bus.b[MSB]) && (sub_sum[MSB] != bus.a[MSB]);
    assign signed_lt   = sub_sum[MSB] ^ sub_ovf;
    assign operands_eq = (bus.a == bus.b);
    assign shift_amt   = bus.b[SHW-1:0];
    assign is_shift    = (bus.op == OP_SLL) || (bus.op == OP_SRL) || (bus.op == OP_SRA);

    // -----------------------------------------------------------------------
    // Per-bit networks: bitwise logic ops and the one-bit shift step
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0]     sll_next;
    logic [WIDTH-1:0]     srl_next;
    logic [WIDTH-1:0]     sra_next;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign not_bits[gi] = ~bus.a[gi];
            assign and_bits[gi] = bus.a[gi] & bus.b[gi];
            assign or_bits[gi]  = bus.a[gi] | bus.b[gi];
            assign xor_bits[gi] = bus.a[gi] ^ bus.b[gi];

            if (gi == 0) begin : g_lsb
                assign sll_next[gi] = 1'b0;
            end else begin : g_not_lsb
                assign sll_next[gi] = work_reg[gi-1];
            end

            if (gi == MSB) begin : g_msb
                assign srl_next[gi] = 1'b0;
                // Arithmetic right shift keeps the sign bit in place.
                assign sra_next[gi] = work_reg[MSB];
            end else begin : g_not_msb
                assign srl_next[gi] = work_reg[gi+1];
                assign sra_next[gi] = work_reg[gi+1];
            end
        end
    endgenerate

    always_comb begin
        sc_res   = '0;
        sc_carry = 1'b0;
        sc_ovf   = 1'b0;
        sc_cmp   = 1'b0;
        case (bus.op)
            OP_ADD: begin
                sc_res   = add_sum[MSB:0];
                sc_carry = add_sum[WIDTH];
                sc_ovf   = add_ovf;
            end
            OP_SUB: begin
                sc_res   = sub_sum[MSB:0];
                sc_carry = sub_sum[WIDTH];
                sc_ovf   = sub_ovf;
            end
            OP_NOT: sc_res = not_bits;
            OP_AND: sc_res = and_bits;
            OP_OR:  sc_res = or_bits;
            OP_XOR: sc_res = xor_bits;
            OP_SLT: begin
                sc_res = {{(WIDTH-1){1'b0}}, signed_lt};
                sc_cmp = signed_lt;
            end
            OP_EQ: begin
                sc_res = {{(WIDTH-1){1'b0}}, operands_eq};
                sc_cmp = operands_eq;
            end
            // Only reached with a zero shift amount: operand passes through.
            OP_SLL, OP_SRL, OP_SRA: sc_res = bus.a;
            default: sc_res = '0;
        endcase
    end

    // -----------------------------------------------------------------------
    // Multi-cycle step logic
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0]     step_work;
    logic                 step_carry;
    logic [2*WIDTH-1:0]   mul_acc_next;
    logic                 last_step;

    always_comb begin
        step_work  = work_reg;
        step_carry = 1'b0;
        case (op_reg)
            OP_SLL: begin
                step_work  = sll_next;
                step_carry = work_reg[MSB];
            end
            OP_SRL: begin
                step_work  = srl_next;
                step_carry = work_reg[0];
            end
            OP_SRA: begin
                step_work  = sra_next;
                step_carry = work_reg[0];
            end
            default: begin
                step_work  = work_reg;
                step_carry = 1'b0;
            end
        endcase
    end

    assign mul_acc_next = work_reg[0] ? (acc_reg + mcand_reg) : acc_reg;
    assign last_step    = (cnt_reg == CNT_ONE);

    // -----------------------------------------------------------------------
    // Control FSM with registered result and flags
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            op_reg     <= '0;
            work_reg   <= '0;
            mcand_reg  <= '0;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            result_reg <= '0;
            zero_reg   <= 1'b0;
            carry_reg  <= 1'b0;
            ovf_reg    <= 1'b0;
            cmp_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        op_reg <= bus.op;
                        if (bus.op == OP_MUL) begin
                            work_reg  <= bus.b;
                            mcand_reg <= {{WIDTH{1'b0}}, bus.a};
                            acc_reg   <= '0;
                            cnt_reg   <= CNT_WIDTH;
                            state_reg <= BUSY;
                        end else if (is_shift && (shift_amt != '0)) begin
                            work_reg  <= bus.a;
                            cnt_reg   <= {1'b0, shift_amt};
                            state_reg <= BUSY;
                        end else begin
                            result_reg <= sc_res;
                            zero_reg   <= (sc_res == '0);
                            carry_reg  <= sc_carry;
                            ovf_reg    <= sc_ovf;
                            cmp_reg    <= sc_cmp;
                            state_reg  <= DONE;
                        end
                    end
                end

                BUSY: begin
                    cnt_reg <= cnt_reg - CNT_ONE;
                    if (op_reg == OP_MUL) begin
                        acc_reg   <= mul_acc_next;
                        mcand_reg <= mcand_reg << 1;
                        work_reg  <= srl_next;
                        if (last_step) begin
                            result_reg <= mul_acc_next[MSB:0];
                            zero_reg   <= (mul_acc_next[MSB:0] == '0);
                            // Any bit above the result width means the product wrapped.
                            carry_reg  <= |mul_acc_next[2*WIDTH-1:WIDTH];
                            ovf_reg    <= 1'b0;
                            cmp_reg    <= 1'b0;
                            state_reg  <= DONE;
                        end
                    end else begin
                        work_reg <= step_work;
                        if (last_step) begin
                            result_reg <= step_work;
                            zero_reg   <= (step_work == '0);
                            carry_reg  <= step_carry;
                            ovf_reg    <= 1'b0;
                            cmp_reg    <= 1'b0;
                            state_reg  <= DONE;
                        end
                    end
                end

                DONE: begin
                    if (bus.out_ready) begin
                        state_reg <= IDLE;
                    end
                end

                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.in_ready      = (state_reg == IDLE);
    assign bus.out_valid     = (state_reg == DONE);
    assign bus.busy          = (state_reg == BUSY);
    assign bus.result        = result_reg;
    assign bus.flag_zero     = zero_reg;
    assign bus.flag_carry    = carry_reg;
    assign bus.flag_overflow = ovf_reg;
    assign bus.flag_cmp      = cmp_reg;
endmodule
